// File: rtl/hmmm_ir_pkg.sv
// Shared constants, extension mode and sizing helper for the instruction queue.
package hmmm_ir_pkg;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_IMM_WIDTH = 8;

  typedef enum logic {
    IMM_ZEXT = 1'b0,
    IMM_SEXT = 1'b1
  } imm_mode_e;

  // Width needed to hold an occupancy value in 0..depth.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ir_imm_ext.sv
// Immediate extractor: takes the low IMM_WIDTH bits of a word and zero- or
// sign-extends them to WIDTH bits.
module ir_imm_ext
  import hmmm_ir_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned IMM_WIDTH = DEF_IMM_WIDTH
) (
  input  logic [WIDTH-1:0] word,
  input  imm_mode_e        mode,
  output logic [WIDTH-1:0] ext
);

  logic fill;

  // Choose the fill bit from the mode and concatenate with the immediate.
  always_comb begin
    fill = (mode == IMM_SEXT) ? word[IMM_WIDTH-1] : 1'b0;
    ext  = {{(WIDTH - IMM_WIDTH){fill}}, word[IMM_WIDTH-1:0]};
  end

endmodule

// File: rtl/ir_queue.sv
// DEPTH-entry instruction queue on the shared tri-state bus. Words are pushed
// from the bus at the tail, the head is presented to the decoder, and the
// head's extended immediate can be driven back onto the bus.
module ir_queue
  import hmmm_ir_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned IMM_WIDTH = DEF_IMM_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  inout  logic [WIDTH-1:0]                data,
  input  logic                            ir_in,
  input  logic                            ir_out,
  input  logic                            imm_sext,
  input  logic                            advance,
  input  logic                            flush,
  output logic [WIDTH-1:0]                ir_data,
  output logic                            ir_valid,
  output logic                            full,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic                            err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             empty;
  logic             push_req;
  logic             pop_ok;
  logic             push_ok;
  logic             err_set;
  logic [WIDTH-1:0] imm_ext;

  // Occupancy flags and push/pop qualification.
  // A push into a full queue is accepted only when the same-cycle pop frees a slot.
  always_comb begin
    empty    = (count == '0);
    full     = (count == CW'(DEPTH));
    push_req = ir_in & ~ir_out;
    pop_ok   = advance & ~empty & ~flush;
    push_ok  = push_req & (~full | pop_ok);
    err_set  = (ir_in & ir_out)
             | (~flush & advance & empty)
             | (~flush & push_req & full & ~advance);
  end

  // Storage, pointers, occupancy and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (err_set) begin
        err <= 1'b1;
      end
      if (flush) begin
        // Flush restarts both pointers at slot 0 so a concurrent push lands there.
        head <= '0;
        if (push_req) begin
          mem[0] <= data;
          tail   <= PW'(1);
          count  <= CW'(1);
        end else begin
          tail  <= '0;
          count <= '0;
        end
      end else begin
        if (push_ok) begin
          mem[tail] <= data;
          tail      <= tail + PW'(1);
        end
        if (pop_ok) begin
          head <= head + PW'(1);
        end
        if (push_ok && !pop_ok) begin
          count <= count + CW'(1);
        end else if (pop_ok && !push_ok) begin
          count <= count - CW'(1);
        end
      end
    end
  end

  // Head word presented to the decoder, forced to zero when empty.
  always_comb begin
    ir_valid = ~empty;
    ir_data  = empty ? '0 : mem[head];
  end

  ir_imm_ext #(
    .WIDTH     (WIDTH),
    .IMM_WIDTH (IMM_WIDTH)
  ) u_imm_ext (
    .word (ir_data),
    .mode (imm_mode_e'(imm_sext)),
    .ext  (imm_ext)
  );

  assign data = ir_out ? imm_ext : 'z;

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_ir_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ir_in = 1'b0;
  logic        ir_out = 1'b0;
  logic        imm_sext = 1'b0;
  logic        advance = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] drv_val = '0;
  wire  [15:0] data;
  logic [15:0] ir_data;
  logic        ir_valid;
  logic        full;
  logic [2:0]  count;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [15:0] mq[$];
  bit          merr = 0;

  // The bench owns the bus whenever the queue is not driving it.
  assign data = ir_out ? 'z : drv_val;

  ir_queue #(.WIDTH(16), .DEPTH(DEPTH), .IMM_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .ir_in    (ir_in),
    .ir_out   (ir_out),
    .imm_sext (imm_sext),
    .advance  (advance),
    .flush    (flush),
    .ir_data  (ir_data),
    .ir_valid (ir_valid),
    .full     (full),
    .count    (count),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_head();
    return (mq.size() > 0) ? mq[0] : 16'h0000;
  endfunction

  function automatic logic [15:0] exp_bus(input logic sext);
    int unsigned lo;
    lo = exp_head() % 256;
    if (sext && lo >= 128) return 16'(lo + 16'hFF00);
    return 16'(lo);
  endfunction

  // Apply the queue rules to the model for the inputs seen at this edge.
  task automatic model_step();
    int  n;
    bit  do_pop;
    n = mq.size();
    if (rst) begin
      mq.delete();
      merr = 0;
    end else if (flush) begin
      mq.delete();
      if (ir_in && ir_out) merr = 1;
      else if (ir_in) mq.push_back(drv_val);
    end else begin
      if (ir_in && ir_out) merr = 1;
      if (advance && n == 0) merr = 1;
      if (ir_in && !ir_out && n == DEPTH && !advance) merr = 1;
      do_pop = advance && n > 0;
      if (do_pop) void'(mq.pop_front());
      if (ir_in && !ir_out && (n < DEPTH || do_pop)) mq.push_back(drv_val);
    end
  endtask

  task automatic step(input logic i_rst, input logic i_in, input logic i_out,
                      input logic i_adv, input logic i_fl, input logic [15:0] d);
    rst = i_rst; ir_in = i_in; ir_out = i_out; advance = i_adv; flush = i_fl;
    drv_val = d;
    @(posedge clk);
    model_step();
    #1;
    rst = 0; ir_in = 0; ir_out = 0; advance = 0; flush = 0;
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 16'h0);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (ir_valid !== 1'b0 || full !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_flags got valid=%b full=%b err=%b want 0 0 0", ir_valid, full, err); end
    total++; if (ir_data !== 16'h0000) begin bad++; $display("FAIL reset_ir_data got=%h want=0000", ir_data); end
  endtask

  task automatic test_push_imm();
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 0, 16'h1234);
    total++; if (ir_data !== 16'h1234 || ir_valid !== 1'b1 || count !== 3'd1) begin
      bad++; $display("FAIL push_first got data=%h valid=%b count=%0d want 1234 1 1", ir_data, ir_valid, count); end
    ir_out = 1; imm_sext = 0; #1;
    total++; if (data !== 16'h0034) begin bad++; $display("FAIL imm_zext1 got=%h want=0034", data); end
    ir_out = 0; #1;
    // Pop and push together at count=1: new word becomes head.
    step(0, 1, 0, 1, 0, 16'h10F0);
    total++; if (ir_data !== 16'h10F0 || count !== 3'd1) begin
      bad++; $display("FAIL push_pop_one got data=%h count=%0d want 10f0 1", ir_data, count); end
    ir_out = 1; imm_sext = 1; #1;
    total++; if (data !== 16'hFFF0) begin bad++; $display("FAIL imm_sext got=%h want=fff0", data); end
    imm_sext = 0; #1;
    total++; if (data !== 16'h00F0) begin bad++; $display("FAIL imm_zext2 got=%h want=00f0", data); end
    ir_out = 0; drv_val = 16'hA5C3; #1;
    total++; if (data !== 16'hA5C3) begin bad++; $display("FAIL bus_release got=%h want=a5c3", data); end
  endtask

  task automatic test_full_order();
    logic [15:0] w [4];
    w[0] = 16'h00A1; w[1] = 16'h00A2; w[2] = 16'h00A3; w[3] = 16'h00A4;
    step(1, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, w[i]);
    total++; if (full !== 1'b1 || count !== 3'd4 || err !== 1'b0) begin
      bad++; $display("FAIL fill got full=%b count=%0d err=%b want 1 4 0", full, count, err); end
    step(0, 1, 0, 0, 0, 16'hBEEF);
    total++; if (err !== 1'b1 || count !== 3'd4 || ir_data !== 16'h00A1) begin
      bad++; $display("FAIL overflow got err=%b count=%0d head=%h want 1 4 00a1", err, count, ir_data); end
    for (int i = 0; i < 4; i++) begin
      total++; if (ir_data !== w[i]) begin bad++; $display("FAIL pop_order[%0d] got=%h want=%h", i, ir_data, w[i]); end
      step(0, 0, 0, 1, 0, 16'h0);
    end
    total++; if (ir_valid !== 1'b0 || ir_data !== 16'h0000 || count !== 3'd0) begin
      bad++; $display("FAIL drained got valid=%b data=%h count=%0d want 0 0000 0", ir_valid, ir_data, count); end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 16'h00B0 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 1, 0, 16'h5550 + 16'(i));
      total++; if (count !== 3'd4 || ir_data !== exp_head() || err !== 1'b0) begin
        bad++; $display("FAIL b2b[%0d] got count=%0d head=%h err=%b want 4 %h 0", i, count, ir_data, err, exp_head()); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (ir_data !== 16'h5554 + 16'(i)) begin
        bad++; $display("FAIL b2b_drain[%0d] got=%h want=%h", i, ir_data, 16'h5554 + 16'(i)); end
      step(0, 0, 0, 1, 0, 16'h0);
    end
  endtask

  task automatic test_flush();
    step(1, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 16'h0C00 + 16'(i));
    step(0, 1, 0, 1, 1, 16'h7777);
    total++; if (count !== 3'd1 || ir_data !== 16'h7777 || err !== 1'b0) begin
      bad++; $display("FAIL flush_push got count=%0d data=%h err=%b want 1 7777 0", count, ir_data, err); end
    step(0, 0, 0, 0, 1, 16'h0);
    total++; if (count !== 3'd0 || ir_valid !== 1'b0) begin
      bad++; $display("FAIL flush_only got count=%0d valid=%b want 0 0", count, ir_valid); end
    step(0, 0, 0, 1, 0, 16'h0);
    total++; if (err !== 1'b1 || count !== 3'd0) begin
      bad++; $display("FAIL pop_empty got err=%b count=%0d want 1 0", err, count); end
  endtask

  task automatic test_contention();
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 0, 16'h1111);
    step(0, 1, 1, 0, 0, 16'h0);
    total++; if (count !== 3'd1 || err !== 1'b1 || ir_data !== 16'h1111) begin
      bad++; $display("FAIL contention got count=%0d err=%b data=%h want 1 1 1111", count, err, ir_data); end
    step(0, 1, 0, 0, 0, 16'h2222);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL pre_rst_count got=%0d want=2", count); end
    step(1, 1, 0, 1, 0, 16'h3333);
    total++; if (count !== 3'd0 || ir_valid !== 1'b0 || full !== 1'b0 || err !== 1'b0 || ir_data !== 16'h0000) begin
      bad++; $display("FAIL mid_rst got count=%0d valid=%b full=%b err=%b data=%h want all 0",
                      count, ir_valid, full, err, ir_data); end
  endtask

  task automatic test_random();
    logic i_rst, i_in, i_out, i_adv, i_fl;
    step(1, 0, 0, 0, 0, 16'h0);
    for (int c = 0; c < 500; c++) begin
      i_rst = ($urandom_range(63) == 0);
      i_fl  = ($urandom_range(15) == 0);
      i_in  = ($urandom_range(1) == 1);
      i_out = ($urandom_range(7) == 0);
      i_adv = ($urandom_range(9) < 4);
      step(i_rst, i_in, i_out, i_adv, i_fl, 16'($urandom));
      total++; if (count !== 3'(mq.size()) || full !== (mq.size() == DEPTH) || ir_valid !== (mq.size() > 0)) begin
        bad++; $display("FAIL rnd_occ[%0d] got count=%0d full=%b valid=%b want %0d", c, count, full, ir_valid, mq.size()); end
      total++; if (ir_data !== exp_head()) begin
        bad++; $display("FAIL rnd_head[%0d] got=%h want=%h", c, ir_data, exp_head()); end
      total++; if (err !== merr) begin bad++; $display("FAIL rnd_err[%0d] got=%b want=%b", c, err, merr); end
      imm_sext = 1'($urandom_range(1));
      ir_out = 1; #1;
      total++; if (data !== exp_bus(imm_sext)) begin
        bad++; $display("FAIL rnd_bus[%0d] got=%h want=%h sext=%b", c, data, exp_bus(imm_sext), imm_sext); end
      ir_out = 0; #1;
    end
  endtask

  initial begin
    test_reset();
    test_push_imm();
    test_full_order();
    test_back_to_back();
    test_flush();
    test_contention();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised successor to the single-entry instruction register: a DEPTH-entry instruction queue on the shared tri-state data bus.
- Instruction words are captured from the bus, presented one at a time at the head to the decoder, and popped when the control unit retires them.
- The immediate field of the head instruction is driven onto the bus, zero- or sign-extended by mode.
- Adds prefetch buffering, flush, occupancy and sticky error reporting.

Parameters:
- WIDTH, 16, instruction/bus width in bits.
- DEPTH, 4, queue entries; power of two, >= 2.
- IMM_WIDTH, 8, immediate field width taken from head[IMM_WIDTH-1:0]; must be < WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- data  inout  WIDTH  shared tri-state bus.
- ir_in  input  1  push: capture data into queue tail.
- ir_out  input  1  drive extended immediate of head onto data.
- imm_sext  input  1  1 = sign-extend immediate, 0 = zero-extend.
- advance  input  1  pop head entry.
- flush  input  1  discard all entries.
- ir_data  output  WIDTH  head instruction; 0 when empty.
- ir_valid  output  1  queue non-empty.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH+1)  occupancy.
- err  output  1  sticky error flag.

Behaviour:
- Reset (rst=1 at posedge): pointers, count=0, ir_valid=0, full=0, err=0, ir_data=0, storage cleared to 0. rst overrides all other inputs.
- Storage is a circular buffer with head/tail pointers that wrap modulo DEPTH. Outputs are registered/pointer-derived with no combinational path from ir_in or advance to ir_data.
- Push: ir_in=1, ir_out=0, and (not full, or advance with non-empty) writes data at tail; count+1.
- Pop: advance=1 with non-empty; count-1. The next entry appears on ir_data the following cycle.
- Push and pop in the same cycle: count is unchanged. This is legal when full (the freed slot is reused) and when count=1 (the new word becomes head).
- Push into an empty queue: the word is visible on ir_data and ir_valid=1 one cycle after the push edge.
- Flush: the queue empties at the edge. With ir_in=1 in the same cycle (and ir_out=0), the queue ends holding only the new word (count=1). advance is ignored during flush.
- Bus drive: when ir_out=1, data = {sign bit or 0 replicated (WIDTH-IMM_WIDTH), head[IMM_WIDTH-1:0]}. When empty, data = 0. When ir_out=0, data is all Z. Combinational from ir_out/imm_sext.
- Error cases: each of the following sets err=1, and err stays set until rst.
  - ir_in while full without advance: push dropped, contents unchanged.
  - advance while empty: no state change.
  - ir_in and ir_out together (bus contention): push suppressed, drive still active.
- Boundaries:
  - count saturates neither way; the error rules above guarantee 0 <= count <= DEPTH.
  - full = (count == DEPTH).
  - Pointer wrap is exercised after DEPTH pushes.

Decomposition:
- Package hmmm_ir_pkg holds:
  - default WIDTH/IMM_WIDTH/DEPTH constants;
  - an extension mode enum (IMM_ZEXT=0, IMM_SEXT=1);
  - the function computing the count width.
- One combinational sub-module, ir_imm_ext (inputs: head word, mode; output: WIDTH-bit extended immediate), is instantiated once for the bus driver.
- FIFO storage and pointers stay in ir_queue.

Test Plan:
- Reset then push 16'h1234 -> next cycle ir_data=16'h1234, ir_valid=1, count=1; ir_out=1, imm_sext=0 -> data=16'h0034.
- Push 16'h10F0; head 16'h10F0 with ir_out=1, imm_sext=1 -> data=16'hFFF0; imm_sext=0 -> 16'h00F0; ir_out=0 -> data all Z.
- Push 4 words A1..A4 (DEPTH=4) -> full=1, count=4; 5th push 16'hBEEF -> dropped, err=1; pop 4 times -> ir_data sequence A1,A2,A3,A4, then ir_valid=0, ir_data=0.
- Full queue, simultaneous ir_in=16'h5555 and advance -> count stays 4, head advances, 16'h5555 emerges after 3 further pops; repeat 8 times to verify pointer wrap and order.
- Count=3, flush with ir_in=16'h7777 -> count=1, ir_data=16'h7777; flush alone -> count=0, ir_valid=0; advance when empty -> err=1, count=0.
- ir_in and ir_out together -> no push, count unchanged, err=1; rst asserted mid-stream with count=2 -> all outputs return to reset values at the next edge.
